// File: rtl/orv64_l2_req_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : orv64_l2_req_arb_pkg
//  Description : Shared types for the orv64 L2 CPU-NoC request arbiter:
//                requester ids, NoC source ids and the CPU<->L2 port structs.
//  Revision    : 1.0 - initial release
// ============================================================================
package orv64_l2_req_arb_pkg;

   // Requester identity; the value doubles as the bit index in grant vectors.
   typedef enum logic {
      ORV64_L2_ARB_IC = 1'b0,
      ORV64_L2_ARB_DC = 1'b1
   } orv64_l2_arb_id_e;

   // NoC source ids stamped into req_tid.src by each requester.
   localparam logic [3:0] ORV64_IC_NOC_SRC_ID = 4'h2;
   localparam logic [3:0] ORV64_DC_NOC_SRC_ID = 4'h1;

   typedef enum logic [1:0] {
      REQ_READ  = 2'd0,
      REQ_WRITE = 2'd1
   } cpu_req_type_e;

   typedef struct packed {
      logic [3:0] src;
      logic [3:0] tid;
   } cpu_tid_t;

   typedef struct packed {
      cpu_req_type_e req_type;
      logic [39:0]   req_paddr;
      logic [63:0]   req_data;
      logic [7:0]    req_mask;
      cpu_tid_t      req_tid;
   } cpu_cache_if_req_t;

   typedef struct packed {
      logic [63:0] resp_data;
      cpu_tid_t    resp_tid;
   } cpu_cache_if_resp_t;

   // Only reads produce a response and therefore occupy an outstanding slot.
   function automatic logic is_read(input cpu_cache_if_req_t r);
      return r.req_type == REQ_READ;
   endfunction

endpackage
`default_nettype wire

// File: rtl/orv64_l2_req_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : orv64_rr_arb2
//  Description : Two-way round-robin arbiter with a backpressure lock. Once a
//                grant is presented and stalled, it is held on the same
//                requester until the downstream handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module orv64_rr_arb2 #(
   parameter logic LAST_GNT_RST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       ready,
   output logic [1:0] gnt,
   output logic       gnt_id,
   output logic       locked
);

   logic last_gnt_q, last_gnt_d;
   logic lock_q,     lock_d;
   logic lock_id_q,  lock_id_d;

   // Grant selection and next-state for round-robin pointer and lock.
   always_comb begin
      gnt_id = 1'b0;
      if (lock_q) begin
         gnt_id = lock_id_q;
      end else if (&req) begin
         gnt_id = ~last_gnt_q;
      end else if (req[1]) begin
         gnt_id = 1'b1;
      end
      gnt[0] = ~gnt_id & req[0];
      gnt[1] =  gnt_id & req[1];

      // A stalled grant locks; a handshake or a dropped valid both unlock.
      lock_d     = (|gnt) & ~ready;
      lock_id_d  = lock_d ? gnt_id : lock_id_q;
      last_gnt_d = ((|gnt) & ready) ? gnt_id : last_gnt_q;
   end

   assign locked = lock_q;

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q <= LAST_GNT_RST;
         lock_q     <= 1'b0;
         lock_id_q  <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         lock_q     <= lock_d;
         lock_id_q  <= lock_id_d;
      end
   end

`ifndef SYNTHESIS
   // The locked requester must keep its request up until it is accepted.
   a_lock_hold: assert property (@(posedge clk) disable iff (rst)
      lock_q |-> req[lock_id_q]);
`endif

endmodule
`default_nettype wire

// File: rtl/orv64_l2_req_arb.sv
`default_nettype none
// ============================================================================
//  Module      : orv64_l2_req_arb
//  Description : Shares the orv64 L2 CPU-NoC port between instruction fetch
//                and the store buffer. Round-robin request grant with lock
//                under backpressure, per-requester outstanding-read limit,
//                and response steering by resp_tid.src.
//  Revision    : 1.0 - initial release
// ============================================================================
module orv64_l2_req_arb
   import orv64_l2_req_arb_pkg::*;
#(
   parameter logic [3:0]  IC_SRC_ID       = ORV64_IC_NOC_SRC_ID,
   parameter logic [3:0]  DC_SRC_ID       = ORV64_DC_NOC_SRC_ID,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  cpu_cache_if_req_t  ic_req,
   input  logic               ic_req_valid,
   output logic               ic_req_ready,
   input  cpu_cache_if_req_t  dc_req,
   input  logic               dc_req_valid,
   output logic               dc_req_ready,
   output cpu_cache_if_req_t  cpu_req,
   output logic               cpu_req_valid,
   input  logic               cpu_req_ready,
   input  cpu_cache_if_resp_t cpu_resp,
   input  logic               cpu_resp_valid,
   output logic               cpu_resp_ready,
   output cpu_cache_if_resp_t ic_resp,
   output logic               ic_resp_valid,
   input  logic               ic_resp_ready,
   output cpu_cache_if_resp_t dc_resp,
   output logic               dc_resp_valid,
   input  logic               dc_resp_ready,
   output logic               idle,
   output logic               err_unknown_src
);

   localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] ic_cnt_q, ic_cnt_d;
   logic [CNT_W-1:0] dc_cnt_q, dc_cnt_d;
   logic             err_unknown_src_q, err_unknown_src_d;

   logic       ic_src_hit, dc_src_hit;
   logic       ic_rsp_hs, dc_rsp_hs;
   logic       ic_elig, dc_elig;
   logic       ic_inc, dc_inc;
   logic [1:0] gnt;
   logic       gnt_id;
   logic       locked;

   assign ic_resp = cpu_resp;
   assign dc_resp = cpu_resp;

   // Response steering by source id; unknown sources are sunk and flagged.
   always_comb begin
      ic_src_hit        = (cpu_resp.resp_tid.src == IC_SRC_ID);
      dc_src_hit        = ~ic_src_hit & (cpu_resp.resp_tid.src == DC_SRC_ID);
      ic_resp_valid     = cpu_resp_valid & ic_src_hit;
      dc_resp_valid     = cpu_resp_valid & dc_src_hit;
      cpu_resp_ready    = ic_src_hit ? ic_resp_ready :
                          dc_src_hit ? dc_resp_ready : 1'b1;
      ic_rsp_hs         = ic_resp_valid & ic_resp_ready;
      dc_rsp_hs         = dc_resp_valid & dc_resp_ready;
      err_unknown_src_d = cpu_resp_valid & ~ic_src_hit & ~dc_src_hit;
   end

   // Eligibility: a read at the limit is blocked unless a response frees a
   // slot this very cycle.
   always_comb begin
      ic_elig = ic_req_valid &
                ~(is_read(ic_req) & (ic_cnt_q == CNT_MAX) & ~ic_rsp_hs);
      dc_elig = dc_req_valid &
                ~(is_read(dc_req) & (dc_cnt_q == CNT_MAX) & ~dc_rsp_hs);
   end

   orv64_rr_arb2 #(
      .LAST_GNT_RST (1'(ORV64_L2_ARB_DC))
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({dc_elig, ic_elig}),
      .ready  (cpu_req_ready),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .locked (locked)
   );

   // Request mux, accept signals and outstanding counter next-state.
   always_comb begin
      cpu_req_valid = |gnt;
      cpu_req       = (gnt_id == 1'(ORV64_L2_ARB_DC)) ? dc_req : ic_req;
      ic_req_ready  = gnt[ORV64_L2_ARB_IC] & cpu_req_ready;
      dc_req_ready  = gnt[ORV64_L2_ARB_DC] & cpu_req_ready;
      ic_inc        = ic_req_ready & is_read(ic_req);
      dc_inc        = dc_req_ready & is_read(dc_req);

      ic_cnt_d = ic_cnt_q;
      if (ic_inc && !ic_rsp_hs && ic_cnt_q != CNT_MAX) begin
         ic_cnt_d = ic_cnt_q + CNT_W'(1);
      end else if (!ic_inc && ic_rsp_hs && ic_cnt_q != '0) begin
         ic_cnt_d = ic_cnt_q - CNT_W'(1);
      end

      dc_cnt_d = dc_cnt_q;
      if (dc_inc && !dc_rsp_hs && dc_cnt_q != CNT_MAX) begin
         dc_cnt_d = dc_cnt_q + CNT_W'(1);
      end else if (!dc_inc && dc_rsp_hs && dc_cnt_q != '0) begin
         dc_cnt_d = dc_cnt_q - CNT_W'(1);
      end

      idle = ~locked & (ic_cnt_q == '0) & (dc_cnt_q == '0);
   end

   assign err_unknown_src = err_unknown_src_q;

   // Outstanding counters and error pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ic_cnt_q          <= '0;
         dc_cnt_q          <= '0;
         err_unknown_src_q <= 1'b0;
      end else begin
         ic_cnt_q          <= ic_cnt_d;
         dc_cnt_q          <= dc_cnt_d;
         err_unknown_src_q <= err_unknown_src_d;
      end
   end

`ifndef SYNTHESIS
   a_ic_no_ovf: assert property (@(posedge clk) disable iff (rst)
      !(ic_inc && !ic_rsp_hs && ic_cnt_q == CNT_MAX));
   a_dc_no_ovf: assert property (@(posedge clk) disable iff (rst)
      !(dc_inc && !dc_rsp_hs && dc_cnt_q == CNT_MAX));
   a_ic_no_udf: assert property (@(posedge clk) disable iff (rst)
      !(ic_rsp_hs && !ic_inc && ic_cnt_q == '0));
   a_dc_no_udf: assert property (@(posedge clk) disable iff (rst)
      !(dc_rsp_hs && !dc_inc && dc_cnt_q == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_orv64_l2_req_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_orv64_l2_req_arb
//  Description : Directed self-checking bench for orv64_l2_req_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_orv64_l2_req_arb;
   import orv64_l2_req_arb_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   cpu_cache_if_req_t  ic_req, dc_req, cpu_req;
   logic               ic_req_valid, ic_req_ready;
   logic               dc_req_valid, dc_req_ready;
   logic               cpu_req_valid, cpu_req_ready;
   cpu_cache_if_resp_t cpu_resp, ic_resp, dc_resp;
   logic               cpu_resp_valid, cpu_resp_ready;
   logic               ic_resp_valid, ic_resp_ready;
   logic               dc_resp_valid, dc_resp_ready;
   logic               idle, err_unknown_src;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   orv64_l2_req_arb dut (
      .clk             (clk),
      .rst             (rst),
      .ic_req          (ic_req),
      .ic_req_valid    (ic_req_valid),
      .ic_req_ready    (ic_req_ready),
      .dc_req          (dc_req),
      .dc_req_valid    (dc_req_valid),
      .dc_req_ready    (dc_req_ready),
      .cpu_req         (cpu_req),
      .cpu_req_valid   (cpu_req_valid),
      .cpu_req_ready   (cpu_req_ready),
      .cpu_resp        (cpu_resp),
      .cpu_resp_valid  (cpu_resp_valid),
      .cpu_resp_ready  (cpu_resp_ready),
      .ic_resp         (ic_resp),
      .ic_resp_valid   (ic_resp_valid),
      .ic_resp_ready   (ic_resp_ready),
      .dc_resp         (dc_resp),
      .dc_resp_valid   (dc_resp_valid),
      .dc_resp_ready   (dc_resp_ready),
      .idle            (idle),
      .err_unknown_src (err_unknown_src)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      ic_req         = '{req_type: REQ_READ, req_paddr: 40'h10_0000_1000,
                         req_data: 64'h1111_2222_3333_4444, req_mask: 8'hFF,
                         req_tid: '{src: 4'h2, tid: 4'h3}};
      dc_req         = '{req_type: REQ_WRITE, req_paddr: 40'h20_0000_2040,
                         req_data: 64'hAAAA_BBBB_CCCC_DDDD, req_mask: 8'h0F,
                         req_tid: '{src: 4'h1, tid: 4'h6}};
      ic_req_valid   = 1'b0;
      dc_req_valid   = 1'b0;
      cpu_req_ready  = 1'b1;
      cpu_resp       = '{resp_data: 64'hDEAD_BEEF_0000_0001, resp_tid: '{src: 4'h2, tid: 4'h3}};
      cpu_resp_valid = 1'b0;
      ic_resp_ready  = 1'b0;
      dc_resp_ready  = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;

      // Reset state
      chk("rst_cpu_req_valid", cpu_req_valid, 1'b0);
      chk("rst_ic_req_ready", ic_req_ready, 1'b0);
      chk("rst_dc_req_ready", dc_req_ready, 1'b0);
      chk("rst_ic_resp_valid", ic_resp_valid, 1'b0);
      chk("rst_dc_resp_valid", dc_resp_valid, 1'b0);
      chk("rst_idle", idle, 1'b1);
      chk("rst_err", err_unknown_src, 1'b0);

      // 1: single dc write
      dc_req_valid = 1'b1;
      #1;
      chk("t1_cpu_req", cpu_req, dc_req);
      chk("t1_cpu_req_valid", cpu_req_valid, 1'b1);
      chk("t1_dc_req_ready", dc_req_ready, 1'b1);
      chk("t1_ic_req_ready", ic_req_ready, 1'b0);
      cyc();
      chk("t1_dc_cnt", dut.dc_cnt_q, 2'd0);
      chk("t1_idle", idle, 1'b1);
      dc_req_valid = 1'b0;

      // 2: tie round-robin on reads (last grant is DC after test 1)
      dc_req.req_type = REQ_READ;
      ic_req_valid    = 1'b1;
      dc_req_valid    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t2_ic_ready_%0d", i), ic_req_ready, (i % 2) == 0);
         chk($sformatf("t2_dc_ready_%0d", i), dc_req_ready, (i % 2) == 1);
         cyc();
      end
      #1;
      chk("t2_blocked_valid", cpu_req_valid, 1'b0);
      chk("t2_ic_cnt", dut.ic_cnt_q, 2'd2);
      chk("t2_dc_cnt", dut.dc_cnt_q, 2'd2);
      chk("t2_idle", idle, 1'b0);
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
      cyc();

      // 4: response steering
      cpu_resp_valid = 1'b1;
      ic_resp_ready  = 1'b1;
      dc_resp_ready  = 1'b1;
      #1;
      chk("t4_ic_resp_valid", ic_resp_valid, 1'b1);
      chk("t4_dc_resp_valid_a", dc_resp_valid, 1'b0);
      chk("t4_cpu_resp_ready_a", cpu_resp_ready, 1'b1);
      chk("t4_ic_resp_data", ic_resp, cpu_resp);
      chk("t4_dc_resp_data", dc_resp, cpu_resp);
      cyc();
      chk("t4_ic_cnt", dut.ic_cnt_q, 2'd1);
      chk("t4_err_a", err_unknown_src, 1'b0);
      cpu_resp.resp_tid.src = 4'h1;
      #1;
      chk("t4_dc_resp_valid", dc_resp_valid, 1'b1);
      chk("t4_ic_resp_valid_b", ic_resp_valid, 1'b0);
      cyc();
      chk("t4_dc_cnt", dut.dc_cnt_q, 2'd1);
      cpu_resp.resp_tid.src = 4'h5;
      ic_resp_ready = 1'b0;
      dc_resp_ready = 1'b0;
      #1;
      chk("t4_ic_resp_valid_c", ic_resp_valid, 1'b0);
      chk("t4_dc_resp_valid_c", dc_resp_valid, 1'b0);
      chk("t4_cpu_resp_ready_c", cpu_resp_ready, 1'b1);
      cyc();
      chk("t4_err_pulse", err_unknown_src, 1'b1);
      chk("t4_ic_cnt_keep", dut.ic_cnt_q, 2'd1);
      chk("t4_dc_cnt_keep", dut.dc_cnt_q, 2'd1);
      cpu_resp_valid = 1'b0;
      cyc();
      chk("t4_err_clear", err_unknown_src, 1'b0);

      // 5: response backpressure, then simultaneous accept and response
      cpu_resp.resp_tid.src = 4'h1;
      cpu_resp_valid        = 1'b1;
      repeat (2) begin
         #1;
         chk("t5_cpu_resp_ready_hold", cpu_resp_ready, 1'b0);
         chk("t5_dc_resp_valid_hold", dc_resp_valid, 1'b1);
         cyc();
         chk("t5_dc_cnt_hold", dut.dc_cnt_q, 2'd1);
      end
      dc_req_valid  = 1'b1;
      dc_resp_ready = 1'b1;
      #1;
      chk("t5_dc_req_ready", dc_req_ready, 1'b1);
      chk("t5_cpu_resp_ready", cpu_resp_ready, 1'b1);
      cyc();
      chk("t5_dc_cnt_same", dut.dc_cnt_q, 2'd1);
      cpu_resp_valid = 1'b0;
      #1;
      chk("t5_dc_read_only", dc_req_ready, 1'b1);
      cyc();
      chk("t5_dc_cnt_full", dut.dc_cnt_q, 2'd2);
      cpu_resp_valid = 1'b1;
      dc_resp_ready  = 1'b0;
      #1;
      chk("t5_dc_blocked", cpu_req_valid, 1'b0);
      cyc();
      dc_resp_ready = 1'b1;
      #1;
      chk("t5_unblock_same_cycle", dc_req_ready, 1'b1);
      cyc();
      chk("t5_dc_cnt_full_keep", dut.dc_cnt_q, 2'd2);
      dc_req_valid   = 1'b0;
      cpu_resp_valid = 1'b0;
      dc_resp_ready  = 1'b0;
      cyc();

      // 3: backpressure lock; first move the round-robin pointer to IC
      ic_req.req_type = REQ_WRITE;
      ic_req_valid    = 1'b1;
      #1;
      chk("t3_pre_ic_ready", ic_req_ready, 1'b1);
      cyc();
      ic_req.req_type = REQ_READ;
      cpu_req_ready   = 1'b0;
      #1;
      chk("t3_c0_cpu_req", cpu_req, ic_req);
      chk("t3_c0_valid", cpu_req_valid, 1'b1);
      chk("t3_c0_ic_ready", ic_req_ready, 1'b0);
      cyc();
      dc_req.req_type = REQ_WRITE;
      dc_req_valid    = 1'b1;
      for (int i = 1; i < 3; i++) begin
         #1;
         chk($sformatf("t3_c%0d_cpu_req", i), cpu_req, ic_req);
         chk($sformatf("t3_c%0d_dc_ready", i), dc_req_ready, 1'b0);
         cyc();
      end
      cpu_req_ready = 1'b1;
      #1;
      chk("t3_ic_hs", ic_req_ready, 1'b1);
      chk("t3_dc_wait", dc_req_ready, 1'b0);
      cyc();
      chk("t3_ic_cnt", dut.ic_cnt_q, 2'd2);
      ic_req_valid = 1'b0;
      #1;
      chk("t3_dc_after", dc_req_ready, 1'b1);
      chk("t3_dc_cpu_req", cpu_req, dc_req);
      cyc();
      dc_req_valid = 1'b0;

      // 6: async reset while locked; pointer first moved to IC
      ic_req.req_type = REQ_WRITE;
      ic_req_valid    = 1'b1;
      #1;
      chk("t6_pre_ic_ready", ic_req_ready, 1'b1);
      cyc();
      cpu_req_ready = 1'b0;
      cyc();
      #1;
      chk("t6_locked_idle", idle, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_idle", idle, 1'b1);
      chk("t6_ic_cnt", dut.ic_cnt_q, 2'd0);
      chk("t6_dc_cnt", dut.dc_cnt_q, 2'd0);
      cyc();
      rst             = 1'b0;
      ic_req.req_type = REQ_READ;
      dc_req.req_type = REQ_READ;
      dc_req_valid    = 1'b1;
      cpu_req_ready   = 1'b1;
      #1;
      chk("t6_tie_ic", ic_req_ready, 1'b1);
      chk("t6_tie_dc", dc_req_ready, 1'b0);
      cyc();
      chk("t6_ic_cnt_after", dut.ic_cnt_q, 2'd1);
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
